// File: rtl/mod_double_reduce.sv
// Conditional subtract stage: reduces the doubled operand 2A (N+1 bits)
// modulo M using a limb-serial subtract, W bits per cycle.
//
// Ports:
//   clk, restn        : clock, async active-low reset
//   start             : one-cycle request, samples in_shift/modulus
//   in_shift [N:0]    : doubled operand 2A (2A < 2M)
//   modulus  [N-1:0]  : odd modulus M
//   result   [N-1:0]  : registered 2A mod M
//   busy, done        : operation in flight / one-cycle completion pulse
module mod_double_reduce #(
  parameter int N = 1024,
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         restn,
  input  logic         start,
  input  logic [N:0]   in_shift,
  input  logic [N-1:0] modulus,
  output logic [N-1:0] result,
  output logic         busy,
  output logic         done
);

  localparam int NL = N / W;
  localparam int KW = (NL > 1) ? $clog2(NL) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    SEL
  } state_t;

  state_t        state;
  logic [N:0]    op_a;
  logic [N-1:0]  op_m;
  logic [N-1:0]  diff;
  logic          borrow;
  logic [KW-1:0] k;

  logic [W-1:0]  a_limb;
  logic [W-1:0]  m_limb;
  logic [W:0]    sub;
  logic          take_diff;

  // Only one W-bit carry chain per cycle; bit W of sub is the borrow-out.
  always_comb begin
    a_limb = op_a[k*W +: W];
    m_limb = op_m[k*W +: W];
    sub    = {1'b0, a_limb} - {1'b0, m_limb} - {{W{1'b0}}, borrow};
  end

  // Bit N of 2A absorbs a final borrow: then 2A >= M regardless.
  assign take_diff = op_a[N] | ~borrow;

  always_ff @(posedge clk or negedge restn) begin
    if (!restn) begin
      state  <= IDLE;
      op_a   <= '0;
      op_m   <= '0;
      diff   <= '0;
      borrow <= 1'b0;
      k      <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_a   <= in_shift;
            op_m   <= modulus;
            borrow <= 1'b0;
            k      <= '0;
            busy   <= 1'b1;
            state  <= SUB;
          end
        end
        SUB: begin
          diff[k*W +: W] <= sub[W-1:0];
          borrow         <= sub[W];
          if (k == KW'(NL - 1)) begin
            state <= SEL;
          end else begin
            k <= k + 1'b1;
          end
        end
        SEL: begin
          result <= take_diff ? diff : op_a[N-1:0];
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_double_reduce.sv
// Directed bench for mod_double_reduce: reference model of the reduction
// and its timing, checked on every falling edge, plus literal results.
module tb_mod_double_reduce;

  localparam int N  = 1024;
  localparam int W  = 64;
  localparam int NL = N / W;

  logic         clk;
  logic         restn;
  logic         start;
  logic [N:0]   in_shift;
  logic [N-1:0] modulus;
  logic [N-1:0] result;
  logic         busy;
  logic         done;

  int checks;
  int failures;
  bit run_cmp;

  mod_double_reduce #(.N(N), .W(W)) dut (
    .clk      (clk),
    .restn    (restn),
    .start    (start),
    .in_shift (in_shift),
    .modulus  (modulus),
    .result   (result),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] reduce(
    input logic [N:0] a, input logic [N-1:0] m);
    logic [N:0] mm;
    logic [N:0] d;
    mm = {1'b0, m};
    d  = a - mm;
    if (a >= mm) return d[N-1:0];
    return a[N-1:0];
  endfunction

  task automatic chk(input string nm,
                     input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got low128=%h want low128=%h",
               nm, act[127:0], exp[127:0]);
    end
  endtask

  // Model: an accepted start schedules done NL+1 edges later.
  logic [N-1:0] m_result = '0;
  logic [N-1:0] m_pend   = '0;
  logic         m_busy   = 1'b0;
  logic         m_done   = 1'b0;
  int           m_cnt    = 0;

  always @(posedge clk or negedge restn) begin
    if (!restn) begin
      m_result = '0;
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_cnt    = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy   = 1'b0;
          m_done   = 1'b1;
          m_result = m_pend;
        end
      end else if (start) begin
        m_pend = reduce(in_shift, modulus);
        m_busy = 1'b1;
        m_cnt  = NL + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("cyc_busy", N'(busy), N'(m_busy));
      chk("cyc_done", N'(done), N'(m_done));
      chk("cyc_result", result, m_result);
    end
  end

  task automatic launch(input logic [N:0] a, input logic [N-1:0] m);
    start    = 1'b1;
    in_shift = a;
    modulus  = m;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_shift = {$urandom, $urandom};
    modulus  = N'({$urandom, $urandom});
  endtask

  // Returns after the edge at which done is seen high.
  task automatic wait_done(input string nm, input int exp_edges);
    int e;
    e = 0;
    while (e < 40) begin
      @(posedge clk);
      #1;
      e++;
      if (done) break;
    end
    chk({nm, "_latency"}, N'(e), N'(exp_edges));
  endtask

  task automatic run_op(input string nm, input logic [N:0] a,
                        input logic [N-1:0] m,
                        input logic [N-1:0] exp);
    launch(a, m);
    wait_done(nm, NL + 1);
    chk(nm, result, exp);
  endtask

  logic [N:0]   a;
  logic [N-1:0] m;
  int           ndone;
  int           nbusy;

  initial begin
    checks   = 0;
    failures = 0;
    run_cmp  = 1'b0;
    start    = 1'b0;
    in_shift = '0;
    modulus  = '0;
    restn    = 1'b1;
    #1 restn = 1'b0;
    #20;
    chk("rst_result", result, '0);
    chk("rst_busy", N'(busy), '0);
    chk("rst_done", N'(done), '0);
    @(posedge clk);
    #1 restn = 1'b1;
    run_cmp = 1'b1;
    @(posedge clk);
    #1;

    // 10 mod 7, with busy counted over the operation
    launch(1025'd10, 1024'd7);
    nbusy = 1;
    ndone = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      #1;
      ndone++;
      if (busy) nbusy++;
    end
    chk("basic_latency", N'(ndone), N'(17));
    chk("basic_busy_cycles", N'(nbusy), N'(17));
    chk("basic_result", result, 1024'd3);
    @(posedge clk);
    #1;
    chk("done_pulse", N'(done), '0);

    run_op("below_m", 1025'd6, 1024'd7, 1024'd6);
    run_op("equal_m", 1025'd7, 1024'd7, 1024'd0);

    a = '0; a[64] = 1'b1;
    m = '0; m[63:0] = '1;
    run_op("borrow64", a, m, 1024'd1);

    a = '0; a[128] = 1'b1;
    m = '0; m[127:0] = '1; m = m - 1024'd2;
    run_op("borrow128", a, m, 1024'd3);

    a = '0; a[N] = 1'b1; a[1] = 1'b1;
    m = '1;
    run_op("topbit", a, m, 1024'd3);

    // start while busy must be ignored
    launch(1025'd10, 1024'd7);
    ndone = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 3 || c == 10) begin
        start    = 1'b1;
        in_shift = 1025'd6;
        modulus  = 1024'd7;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) ndone++;
    end
    chk("ignore_single_done", N'(ndone), N'(1));
    chk("ignore_result", result, 1024'd3);

    // back-to-back: start held during the done cycle
    a = '0; a[64] = 1'b1;
    m = '0; m[63:0] = '1;
    run_op("b2b_first", a, m, 1024'd1);
    launch(1025'd13, 1024'd11);
    wait_done("b2b_second", NL + 1);
    chk("b2b_second", result, 1024'd2);

    // async reset mid-operation
    launch(1025'd10, 1024'd7);
    repeat (8) @(posedge clk);
    #2 restn = 1'b0;
    #1;
    chk("arst_busy", N'(busy), '0);
    chk("arst_done", N'(done), '0);
    chk("arst_result", result, '0);
    @(posedge clk);
    #1 restn = 1'b1;
    ndone = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("arst_no_done", N'(ndone), '0);
    run_op("after_rst", 1025'd12, 1024'd7, 1024'd5);

    @(posedge clk);
    #1;
    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
